// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned SLOTS   = 4;
    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned SHADOWS = SLOTS - 1;

    localparam logic [SLOT_W-1:0] FIRST_SLOT = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOTS - 1);

    // True when the given slot carries the last channel of a frame.
    function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
        return slot == LAST_SLOT;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Two-bit wrapping slot counter; a sync load forces slot 1, a clear forces slot 0.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic load1_i,
    input  logic clr0_i,
    output logic s1_o,
    output logic s0_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    // Load outranks clear, which outranks increment.
    always_comb begin
        slot_d = slot_q;
        if (load1_i) begin
            slot_d = SLOT_W'(1);
        end else if (clr0_i) begin
            slot_d = FIRST_SLOT;
        end else if (inc_i) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= FIRST_SLOT;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign s1_o = slot_q[1];
    assign s0_o = slot_q[0];

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: frame-sync alignment, shadow capture of slots 0..2,
// and a registered frame presented on a..d with a one-cycle valid strobe.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             s1,
    output logic             s0,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    state_t state_q;
    state_t state_d;

    logic [SLOT_W-1:0] slot;
    logic              ctr_inc;
    logic              ctr_load1;
    logic              ctr_clr0;
    logic              cap;
    logic [SLOT_W-1:0] cap_slot;
    logic              frame_done;
    logic              misalign;

    logic [WIDTH-1:0] shadow_q [SHADOWS];
    logic [WIDTH-1:0] shadow_d [SHADOWS];

    logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic [WIDTH-1:0] a_d, b_d, c_d, d_d;
    logic             frame_valid_q, frame_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    assign slot = {s1, s0};

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (ctr_inc),
        .load1_i (ctr_load1),
        .clr0_i  (ctr_clr0),
        .s1_o    (s1),
        .s0_o    (s0)
    );

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        ctr_inc    = 1'b0;
        ctr_load1  = 1'b0;
        ctr_clr0   = 1'b0;
        cap        = 1'b0;
        frame_done = 1'b0;
        misalign   = 1'b0;
        case (state_q)
            HUNT: begin
                if (en && sync) begin
                    cap       = 1'b1;
                    ctr_load1 = 1'b1;
                    state_d   = LOCKED;
                end else begin
                    ctr_clr0 = 1'b1;
                end
            end
            LOCKED: begin
                if (en) begin
                    cap = 1'b1;
                    if (sync && (slot != FIRST_SLOT)) begin
                        // Resynchronise: drop the partial frame, din restarts slot 0.
                        misalign  = 1'b1;
                        ctr_load1 = 1'b1;
                    end else begin
                        ctr_inc    = 1'b1;
                        frame_done = is_last_slot(slot);
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    assign cap_slot = ctr_load1 ? FIRST_SLOT : slot;

    // Shadow capture and output register next values.
    always_comb begin
        shadow_d      = shadow_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        d_d           = d_q;
        frame_valid_d = frame_done;
        sync_err_d    = misalign;
        locked_d      = (state_d == LOCKED);
        if (cap) begin
            case (cap_slot)
                SLOT_W'(0): shadow_d[0] = din;
                SLOT_W'(1): shadow_d[1] = din;
                SLOT_W'(2): shadow_d[2] = din;
                default:    ;
            endcase
        end
        if (frame_done) begin
            a_d = shadow_q[0];
            b_d = shadow_q[1];
            c_d = shadow_q[2];
            d_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            d_q           <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < int'(SHADOWS); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            d_q           <= d_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
            shadow_q      <= shadow_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign d           = d_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=1); expected vectors are hand-computed.
module tb_tdm_demux4;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic en;
    logic sync;
    logic a, b, c, d;
    logic s1, s0;
    logic frame_valid;
    logic locked;
    logic sync_err;

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .en          (en),
        .sync        (sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {a,b,c,d, s1,s0, frame_valid, locked, sync_err}
    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {a, b, c, d, s1, s0, frame_valid, locked, sync_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one sample, clock it in, and settle just after the edge.
    task automatic step(input logic e, input logic s, input logic dv);
        en   = e;
        sync = s;
        din  = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        sync = 1'b0;
        din  = 1'b0;
        #1;
        check("reset", 9'b0000_00_000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        check("idle", 9'b0000_00_000);
        step(1'b0, 1'b1, 1'b1);
        check("hunt_sync_no_en", 9'b0000_00_000);

        // Aligned frame 0,1,0,1
        step(1'b1, 1'b1, 1'b0); check("f1_s0", 9'b0000_01_010);
        step(1'b1, 1'b0, 1'b1); check("f1_s1", 9'b0000_10_010);
        step(1'b1, 1'b0, 1'b0); check("f1_s2", 9'b0000_11_010);
        step(1'b1, 1'b0, 1'b1); check("f1_done", 9'b0101_00_110);
        step(1'b0, 1'b0, 1'b0); check("f1_pulse_end", 9'b0101_00_010);

        // Frame 1,1,0,0 without sync, with a two-cycle gap after slot 1
        step(1'b1, 1'b0, 1'b1); check("f2_s0", 9'b0101_01_010);
        step(1'b1, 1'b0, 1'b1); check("f2_s1", 9'b0101_10_010);
        step(1'b0, 1'b0, 1'b1); check("f2_gap1", 9'b0101_10_010);
        step(1'b0, 1'b1, 1'b1); check("f2_gap2", 9'b0101_10_010);
        step(1'b1, 1'b0, 1'b0); check("f2_s2", 9'b0101_11_010);
        step(1'b1, 1'b0, 1'b0); check("f2_done", 9'b1100_00_110);

        // Aligned sync then misaligned sync at slot 2
        step(1'b1, 1'b1, 1'b0); check("m_s0_sync_ok", 9'b1100_01_010);
        step(1'b1, 1'b0, 1'b0); check("m_s1", 9'b1100_10_010);
        step(1'b1, 1'b1, 1'b1); check("m_sync_err", 9'b1100_01_011);
        step(1'b1, 1'b0, 1'b1); check("m_n1", 9'b1100_10_010);
        step(1'b1, 1'b0, 1'b1); check("m_n2", 9'b1100_11_010);
        step(1'b1, 1'b0, 1'b1); check("m_done", 9'b1111_00_110);

        // Asynchronous reset mid-frame
        step(1'b1, 1'b1, 1'b0); check("r_s0", 9'b1111_01_010);
        step(1'b1, 1'b0, 1'b1); check("r_s1", 9'b1111_10_010);
        #2;
        rst = 1'b1;
        #1;
        check("r_async_clear", 9'b0000_00_000);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // HUNT ignores sync-less data
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'(i & 1));
            check("hunt_ignore", 9'b0000_00_000);
        end

        step(1'b1, 1'b1, 1'b1); check("relock", 9'b0000_01_010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive end of the 4-to-1 multiplexer path. It accepts a serial sample stream in which slots 0..3 carry channels a, b, c, d, as produced when the mux selects step 00→01→10→11. A frame-sync input aligns the block, and a 2-bit slot counter steers samples into shadow registers. Each complete frame is presented on four registered outputs with a one-cycle valid strobe.

## Interface
- WIDTH, 1: sample width in bits for din and a..d.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  serial sample for the current slot.
- en  input  1  din (and sync) valid this cycle; all state holds when 0.
- sync  input  1  marks din as slot 0 (channel a); qualified by en.
- a, b, c, d  output  WIDTH  last complete frame, channels 0..3, registered.
- s1, s0  output  1  slot index of the next expected sample (s1 = MSB).
- frame_valid  output  1  one-cycle pulse when a..d update.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on misaligned sync.

## Operation
- States: HUNT, LOCKED. Reset state: HUNT.
- Reset values: a=b=c=d=0, s1s0=00, frame_valid=0, locked=0, sync_err=0, shadow registers 0.
- HUNT:
  - en=1 and sync=1: store din in shadow[0], set slot=1, go to LOCKED.
  - Any other input: ignored; slot stays 0.
- LOCKED, en=1, sync=0:
  - Store din in shadow[slot]; slot increments modulo 4 (3→0 wraps).
  - At slot=3: on the same edge, a..c load from shadow[0..2] and d loads from din; frame_valid pulses.
- LOCKED, en=1, sync=1, slot=0: normal slot-0 capture; no error.
- LOCKED, en=1, sync=1, slot≠0:
  - sync_err pulses and the partial frame is discarded; a..d and frame_valid are unchanged.
  - din is taken as the new slot 0 and slot becomes 1. The block stays LOCKED.
- en=0: no capture, no slot advance, no pulses; sync is ignored.
- a..d hold their values between frames.
- Reset asserted mid-frame: everything clears immediately, including shadow registers; the block re-enters HUNT.

## Timing
- Latency: a..d and frame_valid update on the same rising edge that samples slot 3 with en=1. They are visible one cycle after that sample is presented.
- s1s0, locked and sync_err are registered and change on the sampling edge.
- Back-to-back frames at en=1 every cycle yield one frame_valid every 4 cycles.
- No combinational path from inputs to outputs.

## Structure
- Package tdm_pkg contains:
  - state enum {HUNT, LOCKED};
  - localparam SLOTS=4;
  - localparam SLOT_W=2.
- Sub-module tdm_slot_ctr: 2-bit wrap counter with clear-to-1 (sync load) and clear-to-0 (reset) controls. It drives s1 and s0.
- The top level holds the FSM, the shadow registers (3×WIDTH) and the output registers.

## Test plan
- Reset then idle:
  - Stimulus: rst pulse; en=0 for 10 cycles.
  - Required: all outputs 0, locked=0, s1s0=00.
- Aligned frame, WIDTH=1:
  - Stimulus: en=1; din=0 with sync=1, then din=1,0,1.
  - Required: a=0, b=1, c=0, d=1 one cycle after the 4th sample; frame_valid high exactly 1 cycle; locked=1.
- Wrap and gaps:
  - Stimulus: two frames (0,1,0,1) then (1,1,0,0), with en=0 for 2 cycles inserted between slots 1 and 2 of frame 2.
  - Required: second frame_valid gives a=1, b=1, c=0, d=0; s1s0 holds during the gap.
- Misaligned sync:
  - Stimulus: after lock, sync=1 at slot 2 with din=1, then 1,1,1.
  - Required: sync_err pulses once; previous a..d retained until the new frame completes as 1,1,1,1.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after slot 1.
  - Required: outputs clear immediately; locked=0; the following sync-less samples are ignored.
- HUNT ignores data:
  - Stimulus: en=1 with sync=0 for 8 cycles.
  - Required: no frame_valid; s1s0 stays 00.
